wpm_calculator: RTL

//  Measures typing speed for one test session and produces WPM as packed BCD: 3 integer

---
 rtl/wpm_calculator_pkg.sv | 32 +++
 rtl/wpm_bin2bcd.sv | 70 +++++++
 rtl/wpm_calculator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wpm_calculator_pkg.sv
// Shared constants, state encodings and helpers for the WPM calculator.
package wpm_calculator_pkg;

  // 60 s/min * 100 cs/s * 100 (hundredths) / 5 chars per word
  localparam int WPM_K     = 120000;
  // Largest displayable value: 999.99 WPM
  localparam int WPM_CLAMP = 99999;
  localparam int NUM_W     = 34;   // width of char_cnt * WPM_K
  localparam int Q_W       = 17;   // clamped quotient width
  localparam int BCD_W     = 20;   // five BCD digits
  localparam int DIV_STEPS = 34;   // one quotient bit per cycle

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STOPPED = 2'd2
  } sess_state_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_DIV  = 2'd1,
    C_BCD  = 2'd2,
    C_DONE = 2'd3
  } calc_state_e;

  // Saturate a raw quotient to the display range.
  function automatic logic [Q_W-1:0] clamp_quot(input logic [NUM_W-1:0] q);
    if (q > NUM_W'(WPM_CLAMP)) return Q_W'(WPM_CLAMP);
    return q[Q_W-1:0];
  endfunction

endpackage

// File: rtl/wpm_bin2bcd.sv
// 17-bit binary to 5-digit packed BCD, double-dabble, one bit per cycle.
// start_i loads the value; done_o pulses one cycle after the 17th shift and
// bcd_o then holds until the next start. abort_i drops any conversion.
module wpm_bin2bcd
  import wpm_calculator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic [Q_W-1:0]   bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W+Q_W-1:0] sh_q, sh_d, adj;
  logic [4:0]           cnt_q, cnt_d;
  logic                 act_q, act_d;
  logic                 done_q, done_d;

  // Add 3 to every BCD digit that is 5 or more before the next shift.
  always_comb begin
    adj = sh_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (sh_q[Q_W+4*i +: 4] >= 4'd5) adj[Q_W+4*i +: 4] = sh_q[Q_W+4*i +: 4] + 4'd3;
    end
  end

  // Load, shift and terminal-count control.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    done_d = 1'b0;
    if (abort_i) begin
      act_d = 1'b0;
    end else if (start_i) begin
      sh_d  = {{BCD_W{1'b0}}, bin_i};
      cnt_d = 5'(Q_W - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      sh_d = adj << 1;
      if (cnt_q == 5'd0) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = sh_q[BCD_W+Q_W-1:Q_W];

endmodule

// File: rtl/wpm_calculator.sv
// Typing-speed meter: session FSM, centisecond prescaler, char/time counters,
// restoring divider and BCD conversion feeding the seven-segment controller.
//
// Session FSM
//   state     | meaning
//   S_IDLE    | after reset, counters frozen, char_valid ignored
//   S_RUN     | counting chars and centiseconds, periodic recalculation
//   S_STOPPED | counters frozen at the stop values
// Calc FSM
//   state     | meaning
//   C_IDLE    | waiting for a launch
//   C_DIV     | 34-cycle restoring division num/den
//   C_BCD     | double-dabble of the clamped quotient
//   C_DONE    | load WPM outputs, pulse result_valid
module wpm_calculator
  import wpm_calculator_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int UPDATE_CS = 100,
  parameter int CHAR_W    = 16,
  parameter int TIME_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        test_start,
  input  logic        test_stop,
  input  logic        char_valid,
  output logic [11:0] wpm_integer,
  output logic [7:0]  wpm_decimal,
  output logic        running,
  output logic        busy,
  output logic        result_valid
);

  localparam int PRESC_DIV = CLK_HZ / 100;
  localparam int PRE_W     = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int UPD_W     = (UPDATE_CS > 1) ? $clog2(UPDATE_CS) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PRESC_DIV - 1);
  localparam logic [UPD_W-1:0] UPD_TC = UPD_W'(UPDATE_CS - 1);

  sess_state_e        sess_q, sess_d;
  calc_state_e        calc_q, calc_d;
  logic [CHAR_W-1:0]  char_q, char_d;
  logic [TIME_W-1:0]  elapsed_q, elapsed_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [UPD_W-1:0]   upd_q, upd_d;
  logic               pend_q, pend_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [TIME_W-1:0]  den_q, den_d;
  logic [TIME_W-1:0]  rem_q, rem_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [11:0]        wpm_int_q, wpm_int_d;
  logic [7:0]         wpm_dec_q, wpm_dec_d;
  logic               rv_q, rv_d;

  logic               per_req, stop_evt, fin_req, launch;
  logic [TIME_W:0]    rem_sh;
  logic               ge;
  logic               bcd_start, bcd_done;
  logic [Q_W-1:0]     bcd_bin;
  logic [BCD_W-1:0]   bcd;

  // Session FSM, prescaler and saturating counters; start overrides everything.
  always_comb begin
    sess_d    = sess_q;
    char_d    = char_q;
    elapsed_d = elapsed_q;
    presc_d   = presc_q;
    upd_d     = upd_q;
    per_req   = 1'b0;
    stop_evt  = 1'b0;
    if (test_start) begin
      sess_d    = S_RUN;
      char_d    = '0;
      elapsed_d = '0;
      presc_d   = '0;
      upd_d     = UPD_TC;
    end else if (sess_q == S_RUN) begin
      if (char_valid && (char_q != '1)) char_d = char_q + 1'b1;
      if (presc_q == PRE_TC) begin
        presc_d = '0;
        if (elapsed_q != '1) elapsed_d = elapsed_q + 1'b1;
        if (upd_q == '0) begin
          per_req = 1'b1;
          upd_d   = UPD_TC;
        end else begin
          upd_d = upd_q - 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (test_stop) begin
        sess_d   = S_STOPPED;
        stop_evt = 1'b1;
      end
    end
  end

  // A final request waits for an idle engine; a periodic one only fires if idle.
  assign fin_req = pend_q | stop_evt;
  assign launch  = !test_start && (calc_q == C_IDLE) && (fin_req || per_req);
  assign pend_d  = !test_start && fin_req && !launch;

  assign rem_sh = {rem_q, num_q[NUM_W-1]};
  assign ge     = (rem_sh >= {1'b0, den_q});

  // Calc FSM: snapshot at launch, divide, convert, publish both fields at once.
  always_comb begin
    calc_d    = calc_q;
    num_d     = num_q;
    den_d     = den_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    wpm_int_d = wpm_int_q;
    wpm_dec_d = wpm_dec_q;
    rv_d      = 1'b0;
    bcd_start = 1'b0;
    bcd_bin   = '0;
    if (test_start) begin
      calc_d    = C_IDLE;
      wpm_int_d = '0;
      wpm_dec_d = '0;
    end else begin
      case (calc_q)
        C_IDLE: begin
          if (launch) begin
            // Counter next-values so a char coincident with stop is included.
            num_d = NUM_W'(char_d) * NUM_W'(WPM_K);
            den_d = elapsed_d;
            rem_d = '0;
            cnt_d = 6'(DIV_STEPS - 1);
            if (elapsed_d == '0) begin
              calc_d    = C_BCD;
              bcd_start = 1'b1;
            end else begin
              calc_d = C_DIV;
            end
          end
        end
        C_DIV: begin
          // Quotient bits shift into num_q as dividend bits shift out.
          num_d = {num_q[NUM_W-2:0], ge};
          rem_d = ge ? TIME_W'(rem_sh - {1'b0, den_q}) : rem_sh[TIME_W-1:0];
          if (cnt_q == 6'd0) begin
            calc_d    = C_BCD;
            bcd_start = 1'b1;
            bcd_bin   = clamp_quot(num_d);
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        C_BCD: begin
          if (bcd_done) calc_d = C_DONE;
        end
        C_DONE: begin
          wpm_int_d = bcd[19:8];
          wpm_dec_d = bcd[7:0];
          rv_d      = 1'b1;
          calc_d    = C_IDLE;
        end
        default: calc_d = C_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sess_q    <= S_IDLE;
      calc_q    <= C_IDLE;
      char_q    <= '0;
      elapsed_q <= '0;
      presc_q   <= '0;
      upd_q     <= '0;
      pend_q    <= 1'b0;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      wpm_int_q <= '0;
      wpm_dec_q <= '0;
      rv_q      <= 1'b0;
    end else begin
      sess_q    <= sess_d;
      calc_q    <= calc_d;
      char_q    <= char_d;
      elapsed_q <= elapsed_d;
      presc_q   <= presc_d;
      upd_q     <= upd_d;
      pend_q    <= pend_d;
      num_q     <= num_d;
      den_q     <= den_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      wpm_int_q <= wpm_int_d;
      wpm_dec_q <= wpm_dec_d;
      rv_q      <= rv_d;
    end
  end

  wpm_bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort_i (test_start),
    .start_i (bcd_start),
    .bin_i   (bcd_bin),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  assign wpm_integer  = wpm_int_q;
  assign wpm_decimal  = wpm_dec_q;
  assign running      = (sess_q == S_RUN);
  assign busy         = (calc_q != C_IDLE);
  assign result_valid = rv_q;

endmodule
